// File: rtl/pvr_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pvr_vram_arbiter
// Description : Shares the 32-bit PVR VRAM port between parser, ISP and texture
//               fetch clients. Optional round-robin via PVR_VRAM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pvr_vram_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int ADDR_W          = 24,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_data,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_wait,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  output logic                      err_stray
);

  localparam int c_TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_TAG_W:0]   c_NREQ = (c_TAG_W+1)'(NUM_REQ);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [NUM_REQ-1:0] c_ONE  = NUM_REQ'(1);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_CMD  = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic                w_issue;
  logic                w_accept;

  logic [NUM_REQ-1:0]  w_elig;
  logic                w_rd_ok;
  logic                w_found;
  logic [c_TAG_W-1:0]  w_win;
  logic [c_TAG_W:0]    w_idx;
  logic [c_TAG_W-1:0]  w_base;
  logic                w_win_rd;

  logic [NUM_REQ-1:0]  r_req_ack;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_err_stray;
  logic [c_TAG_W-1:0]  r_win;

  logic [c_TAG_W-1:0]  r_tags [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                w_push;
  logic                w_pop;

`ifdef PVR_VRAM_ARB_RR_EN
  logic [c_TAG_W-1:0]  r_ptr;
  localparam logic [c_TAG_W-1:0] c_LAST = c_TAG_W'(NUM_REQ - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (r_win == c_LAST) ? '0 : r_win + c_TAG_W'(1);
    end
  end

  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  // A client acked this cycle still holds its request; mask it so it is not re-issued.
  assign w_rd_ok = (r_count != c_FULL);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = !r_req_ack[i] && (req_rd[i] ? w_rd_ok : req_wr[i]);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, w_base} + (c_TAG_W+1)'(k);
      if (w_idx >= c_NREQ) begin
        w_idx = w_idx - c_NREQ;
      end
      if (w_elig[w_idx[c_TAG_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[c_TAG_W-1:0];
      end
    end
  end

  assign w_win_rd = req_rd[w_win];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_found)   w_state_nxt = c_ST_CMD;
      c_ST_CMD:  if (!mem_wait) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue  = (r_state == c_ST_IDLE) && w_found;
    w_accept = (r_state == c_ST_CMD) && !mem_wait;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_ack   <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_win       <= '0;
    end else begin
      r_req_ack <= '0;
      if (w_issue) begin
        r_mem_rd    <= w_win_rd;
        r_mem_wr    <= !w_win_rd;
        r_mem_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
        r_mem_wdata <= req_wdata[w_win*32 +: 32];
        r_win       <= w_win;
      end else if (w_accept) begin
        r_mem_rd  <= 1'b0;
        r_mem_wr  <= 1'b0;
        r_req_ack <= c_ONE << r_win;
      end
    end
  end

  // Tag FIFO: read data returns in issue order, so the head tag names its owner.
  assign w_push = w_accept && r_mem_rd;
  assign w_pop  = mem_rvalid && (r_count != '0);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= r_win;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + c_PTR_W'(1);
        r_rsp_valid <= c_ONE << r_tags[r_rd_ptr];
        r_rsp_data  <= mem_rdata;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (mem_rvalid && (r_count == '0)) begin
        r_err_stray <= 1'b1;
      end
    end
  end

  assign req_ack   = r_req_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err_stray = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_pvr_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pvr_vram_arbiter
// Description : Randomised bench for pvr_vram_arbiter with a transaction-level
//               reference model of arbitration, command hold and tag routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pvr_vram_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 24;
  localparam int MAXO    = 4;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_rd = '0;
  logic [NUM_REQ-1:0]        req_wr = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*32-1:0]     req_wdata = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_data;
  logic                      mem_rd;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [31:0]               mem_wdata;
  logic                      mem_wait = 1'b0;
  logic                      mem_rvalid = 1'b0;
  logic [31:0]               mem_rdata = '0;
  logic                      err_stray;

  always #5 clock = ~clock;

  pvr_vram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO)) u_dut (
    .clock(clock), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wait(mem_wait), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_stray(err_stray)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: expected outputs of the current cycle.
  bit          m_active = 0;
  bit          m_rd = 0;
  int          m_win = 0;
  int          m_ptr = 0;
  logic [23:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [2:0]  m_ack = '0;
  logic [2:0]  m_rsp = '0;
  logic [31:0] m_rdat = '0;
  bit          m_err = 0;
  int          m_tags[$];

  task automatic model_update();
    int   size0;
    logic [2:0] n_ack;
    logic [2:0] n_rsp;
    bit   found;
    int   base;
    if (reset) begin
      m_active = 0; m_ack = '0; m_rsp = '0; m_err = 0; m_ptr = 0;
      m_tags.delete();
      return;
    end
    size0 = m_tags.size();
    n_ack = '0;
    n_rsp = '0;
    if (mem_rvalid) begin
      if (size0 > 0) begin
        n_rsp  = 3'(1 << m_tags[0]);
        m_rdat = mem_rdata;
        void'(m_tags.pop_front());
      end else begin
        m_err = 1;
      end
    end
    if (m_active) begin
      if (!mem_wait) begin
        n_ack = 3'(1 << m_win);
        if (m_rd) m_tags.push_back(m_win);
        m_ptr    = (m_win + 1) % NUM_REQ;
        m_active = 0;
      end
    end else begin
      found = 0;
      base  = 0;
`ifdef PVR_VRAM_ARB_RR_EN
      base = m_ptr;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        bit el;
        j  = (base + k) % NUM_REQ;
        el = !m_ack[j] && (req_rd[j] ? (size0 < MAXO) : req_wr[j]);
        if (!found && el) begin
          found   = 1;
          m_win   = j;
          m_rd    = req_rd[j];
          m_addr  = req_addr[j*ADDR_W +: ADDR_W];
          m_wdata = req_wdata[j*32 +: 32];
        end
      end
      m_active = found;
    end
    m_ack = n_ack;
    m_rsp = n_rsp;
  endtask

  task automatic compare();
    check("mem_rd", {31'b0, mem_rd}, {31'b0, m_active && m_rd});
    check("mem_wr", {31'b0, mem_wr}, {31'b0, m_active && !m_rd});
    if (m_active) check("mem_addr", {8'b0, mem_addr}, {8'b0, m_addr});
    if (m_active && !m_rd) check("mem_wdata", mem_wdata, m_wdata);
    check("req_ack", {29'b0, req_ack}, {29'b0, m_ack});
    check("rsp_valid", {29'b0, rsp_valid}, {29'b0, m_rsp});
    if (m_rsp != 0) check("rsp_data", rsp_data, m_rdat);
    check("err_stray", {31'b0, err_stray}, {31'b0, m_err});
  endtask

  // Stimulus: clients and memory.
  typedef struct {int cli; bit rd; logic [23:0] addr; logic [31:0] data;} cmd_t;
  cmd_t scr[$];
  bit   c_act[NUM_REQ];
  bit   c_drop[NUM_REQ];
  bit   cli_rand = 0;
  bit   mem_auto = 0;
  bit   ret_en = 0;
  int   wait_pct = 0;
  int   dmin = 1;
  int   dmax = 1;
  int   mem_pend[$];
  bit   p_mem_rd = 0;
  int   n_rd_acc = 0;
  int   ack_log[$];
  int   rsp_log[$];

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    model_update();
    compare();
    if (p_mem_rd && !mem_wait) begin
      mem_pend.push_back(cyc + $urandom_range(dmin, dmax));
      n_rd_acc++;
    end
    p_mem_rd = mem_rd;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ack[i])   ack_log.push_back(i);
      if (rsp_valid[i]) rsp_log.push_back(i);
    end
  endtask

  task automatic drive_clients();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (c_drop[i]) begin
        req_rd[i] = 1'b0; req_wr[i] = 1'b0;
        c_drop[i] = 0; c_act[i] = 0;
      end else if (c_act[i]) begin
        if (req_ack[i]) c_drop[i] = 1;
      end else begin
        int   f;
        cmd_t c;
        f = -1;
        foreach (scr[k]) if (f < 0 && scr[k].cli == i) f = k;
        if (f >= 0) begin
          c = scr[f];
          scr.delete(f);
        end else if (cli_rand && $urandom_range(0, 2) == 0) begin
          c.cli = i; c.rd = 1'($urandom_range(0, 1));
          c.addr = 24'($urandom); c.data = $urandom;
          f = 0;
        end
        if (f >= 0) begin
          req_rd[i] = c.rd; req_wr[i] = !c.rd;
          req_addr[i*ADDR_W +: ADDR_W] = c.addr;
          req_wdata[i*32 +: 32] = c.data;
          c_act[i] = 1;
        end
      end
    end
  endtask

  task automatic drive_mem();
    if (!mem_auto) return;
    mem_wait = ($urandom_range(0, 99) < wait_pct);
    if (ret_en && mem_pend.size() > 0 && mem_pend[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      void'(mem_pend.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic cycle();
    step();
    drive_clients();
    drive_mem();
  endtask

  function automatic bit quiet();
    bit q;
    q = (scr.size() == 0) && (mem_pend.size() == 0) && (m_tags.size() == 0) && !m_active;
    for (int i = 0; i < NUM_REQ; i++) if (c_act[i]) q = 0;
    return q;
  endfunction

  task automatic run_until_quiet(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && !quiet()) begin
      cycle();
      k++;
    end
    check(tag, {31'b0, quiet()}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_rd = '0; req_wr = '0; mem_wait = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin c_act[i] = 0; c_drop[i] = 0; end
    scr.delete();
    mem_pend.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int nwr;
    int n0;

    // Reset values
    mem_auto = 0;
    do_reset();
    check("rst_ack", {29'b0, req_ack}, 32'd0);
    check("rst_rsp_valid", {29'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_mem_cmd", {30'b0, mem_rd, mem_wr}, 32'd0);
    check("rst_mem_addr", {8'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_err", {31'b0, err_stray}, 32'd0);

    // Single read from client 1 with fixed-latency return
    scr.push_back('{1, 1'b1, 24'h000100, 32'h0});
    drive_clients();
    step();
    check("t1_mem_rd_cyc1", {31'b0, mem_rd}, 32'd1);
    check("t1_mem_addr", {8'b0, mem_addr}, 32'h000100);
    drive_clients();
    step();
    check("t1_ack_cyc2", {29'b0, req_ack}, 32'b010);
    drive_clients();
    step();
    drive_clients();
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 1'b0;
    check("t1_rsp_valid", {29'b0, rsp_valid}, 32'b010);
    check("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    drive_clients();

    // All three clients read at once
    do_reset();
    mem_auto = 1; wait_pct = 0; dmin = 2; dmax = 2; ret_en = 1;
    ack_log.delete(); rsp_log.delete();
    for (int i = 0; i < NUM_REQ; i++) scr.push_back('{i, 1'b1, 24'(16 * i), 32'h0});
    drive_clients();
    run_until_quiet("t2_quiet", 100);
    check("t2_n_ack", ack_log.size(), 32'd3);
    check("t2_n_rsp", rsp_log.size(), 32'd3);
    for (int k = 0; k < 3 && k < ack_log.size(); k++) check("t2_ack_order", ack_log[k], k);
    for (int k = 0; k < 3 && k < rsp_log.size(); k++) check("t2_rsp_order", rsp_log[k], k);

    // Four rounds held by every client
    do_reset();
    ack_log.delete();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < NUM_REQ; i++) scr.push_back('{i, 1'b1, 24'(256 * r + i), 32'h0});
    drive_clients();
    run_until_quiet("t3_quiet", 400);
    check("t3_n_ack", ack_log.size(), 32'd12);
`ifdef PVR_VRAM_ARB_RR_EN
    for (int k = 0; k < ack_log.size(); k++) check("t3_rr_order", ack_log[k], k % 3);
`endif

    // Write held under mem_wait for five cycles
    mem_auto = 0; mem_wait = 1'b1; mem_rvalid = 1'b0;
    ack_log.delete();
    scr.push_back('{0, 1'b0, 24'h000040, 32'h12345678});
    drive_clients();
    nwr = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (mem_wr) nwr++;
      drive_clients();
      mem_wait = (nwr <= 5);
    end
    mem_wait = 1'b0;
    check("t4_wr_cycles", nwr, 32'd6);
    check("t4_n_ack", ack_log.size(), 32'd1);

    // Outstanding limit: six reads, no returns
    mem_auto = 1; wait_pct = 0; dmin = 1; dmax = 1; ret_en = 0;
    n_rd_acc = 0;
    for (int k = 0; k < 6; k++) scr.push_back('{0, 1'b1, 24'(k * 4), 32'h0});
    drive_clients();
    for (int k = 0; k < 40; k++) cycle();
    check("t5_accepted_4", n_rd_acc, 32'd4);
    mem_auto = 0; mem_wait = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A50001;
    void'(mem_pend.pop_front());
    step();
    mem_rvalid = 1'b0;
    drive_clients();
    for (int k = 0; k < 10; k++) begin step(); drive_clients(); end
    check("t5_accepted_5", n_rd_acc, 32'd5);
    mem_auto = 1; ret_en = 1;
    run_until_quiet("t5_quiet", 200);
    check("t5_accepted_6", n_rd_acc, 32'd6);

    // Randomised traffic
    do_reset();
    mem_auto = 1; wait_pct = 30; dmin = 0; dmax = 6; ret_en = 1; cli_rand = 1;
    for (int k = 0; k < 2500; k++) cycle();
    cli_rand = 0;
    run_until_quiet("rand_quiet", 600);

    // Stray read data
    mem_auto = 0;
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    step();
    mem_rvalid = 1'b0;
    check("t6_no_rsp", {29'b0, rsp_valid}, 32'd0);
    check("t6_err_set", {31'b0, err_stray}, 32'd1);
    for (int k = 0; k < 5; k++) step();
    check("t6_err_sticky", {31'b0, err_stray}, 32'd1);

    // Reset with reads in flight, then their data returns
    do_reset();
    check("t7_err_clear", {31'b0, err_stray}, 32'd0);
    mem_auto = 1; wait_pct = 0; ret_en = 0;
    scr.push_back('{1, 1'b1, 24'h000200, 32'h0});
    scr.push_back('{1, 1'b1, 24'h000204, 32'h0});
    drive_clients();
    for (int k = 0; k < 10; k++) cycle();
    n0 = m_tags.size();
    check("t7_inflight", n0, 32'd2);
    mem_auto = 0;
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
    step();
    mem_rvalid = 1'b0;
    check("t7_no_rsp", {29'b0, rsp_valid}, 32'd0);
    check("t7_err_set", {31'b0, err_stray}, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
